dec_rf_regfile: RTL and testbench

Two-write, four-read architectural register file with a busy scoreboard, answering the decoder's register-file request interface in the dual-issue core. Each cycle it accepts up to two writebacks, which are committed results, and up to four operand reads, two per issue slot. Read data comes back one cycle later. A per-register busy scoreboard tells the decoder whether each returned operand is final or still pending from an in-flight producer.

---
 rtl/dec_rf_regfile.sv | 161 ++++++++++++++++
 tb/tb_dec_rf_regfile.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/dec_rf_regfile.sv
`default_nettype none
// ============================================================================
//  Module      : dec_rf_regfile
//  Description : Two-write, four-read register file with a per-entry busy
//                scoreboard. Reads are registered, with write-through bypass.
//  Revision    : 1.0 - initial release
// ============================================================================
module dec_rf_regfile #(
    parameter int REGNAME_WIDTH = 5,
    parameter int DATA_WIDTH    = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,

    input  logic                     write1_en,
    input  logic [REGNAME_WIDTH-1:0] write1_addr,
    input  logic [DATA_WIDTH-1:0]    write1_data,
    input  logic                     write2_en,
    input  logic [REGNAME_WIDTH-1:0] write2_addr,
    input  logic [DATA_WIDTH-1:0]    write2_data,

    input  logic                     read11_en,
    input  logic [REGNAME_WIDTH-1:0] read11_addr,
    output logic [DATA_WIDTH-1:0]    read11_data,
    output logic                     read11_rdy,
    input  logic                     read12_en,
    input  logic [REGNAME_WIDTH-1:0] read12_addr,
    output logic [DATA_WIDTH-1:0]    read12_data,
    output logic                     read12_rdy,
    input  logic                     read21_en,
    input  logic [REGNAME_WIDTH-1:0] read21_addr,
    output logic [DATA_WIDTH-1:0]    read21_data,
    output logic                     read21_rdy,
    input  logic                     read22_en,
    input  logic [REGNAME_WIDTH-1:0] read22_addr,
    output logic [DATA_WIDTH-1:0]    read22_data,
    output logic                     read22_rdy,

    input  logic                     alloc1_en,
    input  logic [REGNAME_WIDTH-1:0] alloc1_addr,
    input  logic                     alloc2_en,
    input  logic [REGNAME_WIDTH-1:0] alloc2_addr
);

    localparam int C_NREGS  = 2 ** REGNAME_WIDTH;
    localparam int C_NPORTS = 4;

    logic [DATA_WIDTH-1:0]    r_mem [C_NREGS];
    logic [C_NREGS-1:0]       r_busy;
    logic [C_NREGS-1:0]       w_busy_nxt;

    logic                     w_wr1_act;
    logic                     w_wr2_act;
    logic                     w_al1_act;
    logic                     w_al2_act;

    logic [C_NPORTS-1:0]      w_rd_en;
    logic [REGNAME_WIDTH-1:0] w_rd_addr [C_NPORTS];
    logic [DATA_WIDTH-1:0]    w_rd_data [C_NPORTS];
    logic [C_NPORTS-1:0]      w_rd_rdy;
    logic [DATA_WIDTH-1:0]    r_rd_data [C_NPORTS];
    logic [C_NPORTS-1:0]      r_rd_rdy;

    // Index 0 is hardwired: qualifying every strobe keeps x0 free of state.
    assign w_wr1_act = write1_en && (write1_addr != '0);
    assign w_wr2_act = write2_en && (write2_addr != '0);
    assign w_al1_act = alloc1_en && (alloc1_addr != '0);
    assign w_al2_act = alloc2_en && (alloc2_addr != '0);

    assign w_rd_en      = {read22_en, read21_en, read12_en, read11_en};
    assign w_rd_addr[0] = read11_addr;
    assign w_rd_addr[1] = read12_addr;
    assign w_rd_addr[2] = read21_addr;
    assign w_rd_addr[3] = read22_addr;

    // Slot 2 is assigned last so it wins a same-index collision.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < C_NREGS; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_wr1_act) begin
                r_mem[write1_addr] <= write1_data;
            end
            if (w_wr2_act) begin
                r_mem[write2_addr] <= write2_data;
            end
        end
    end

    // Allocs are applied after write clears: they belong to a newer producer.
    always_comb begin
        w_busy_nxt = r_busy;
        if (w_wr1_act) begin
            w_busy_nxt[write1_addr] = 1'b0;
        end
        if (w_wr2_act) begin
            w_busy_nxt[write2_addr] = 1'b0;
        end
        if (w_al1_act) begin
            w_busy_nxt[alloc1_addr] = 1'b1;
        end
        if (w_al2_act) begin
            w_busy_nxt[alloc2_addr] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy <= '0;
        end else begin
            r_busy <= w_busy_nxt;
        end
    end

    // Bypass view seen by readers: same-cycle writes included, allocs not.
    always_comb begin
        for (int p = 0; p < C_NPORTS; p++) begin
            w_rd_data[p] = r_mem[w_rd_addr[p]];
            w_rd_rdy[p]  = ~r_busy[w_rd_addr[p]];
            if (w_rd_addr[p] == '0) begin
                w_rd_data[p] = '0;
                w_rd_rdy[p]  = 1'b1;
            end else if (w_wr2_act && (write2_addr == w_rd_addr[p])) begin
                w_rd_data[p] = write2_data;
                w_rd_rdy[p]  = 1'b1;
            end else if (w_wr1_act && (write1_addr == w_rd_addr[p])) begin
                w_rd_data[p] = write1_data;
                w_rd_rdy[p]  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int p = 0; p < C_NPORTS; p++) begin
                r_rd_data[p] <= '0;
            end
            r_rd_rdy <= '0;
        end else begin
            for (int p = 0; p < C_NPORTS; p++) begin
                if (w_rd_en[p]) begin
                    r_rd_data[p] <= w_rd_data[p];
                    r_rd_rdy[p]  <= w_rd_rdy[p];
                end
            end
        end
    end

    assign read11_data = r_rd_data[0];
    assign read12_data = r_rd_data[1];
    assign read21_data = r_rd_data[2];
    assign read22_data = r_rd_data[3];
    assign read11_rdy  = r_rd_rdy[0];
    assign read12_rdy  = r_rd_rdy[1];
    assign read21_rdy  = r_rd_rdy[2];
    assign read22_rdy  = r_rd_rdy[3];

endmodule
`default_nettype wire

// File: tb/tb_dec_rf_regfile.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dec_rf_regfile
//  Description : Self-checking bench for dec_rf_regfile against an array model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dec_rf_regfile;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        we1, we2, ae1, ae2;
    logic [4:0]  wa1, wa2, aa1, aa2;
    logic [31:0] wd1, wd2;
    logic        re [4];
    logic [4:0]  ra [4];
    logic [31:0] rd [4];
    logic        rr [4];

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state.
    logic [31:0] m_mem  [32];
    logic        m_busy [32];
    logic [31:0] e_data [4];
    logic        e_rdy  [4];

    always #5 clk = ~clk;

    dec_rf_regfile #(.REGNAME_WIDTH(5), .DATA_WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .write1_en(we1), .write1_addr(wa1), .write1_data(wd1),
        .write2_en(we2), .write2_addr(wa2), .write2_data(wd2),
        .read11_en(re[0]), .read11_addr(ra[0]), .read11_data(rd[0]), .read11_rdy(rr[0]),
        .read12_en(re[1]), .read12_addr(ra[1]), .read12_data(rd[1]), .read12_rdy(rr[1]),
        .read21_en(re[2]), .read21_addr(ra[2]), .read21_data(rd[2]), .read21_rdy(rr[2]),
        .read22_en(re[3]), .read22_addr(ra[3]), .read22_data(rd[3]), .read22_rdy(rr[3]),
        .alloc1_en(ae1), .alloc1_addr(aa1),
        .alloc2_en(ae2), .alloc2_addr(aa2)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic clear_inputs();
        we1 = 0; we2 = 0; ae1 = 0; ae2 = 0;
        wa1 = 0; wa2 = 0; aa1 = 0; aa2 = 0;
        wd1 = 0; wd2 = 0;
        for (int p = 0; p < 4; p++) begin
            re[p] = 0;
            ra[p] = 0;
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) begin
            m_mem[i]  = 0;
            m_busy[i] = 0;
        end
        for (int p = 0; p < 4; p++) begin
            e_data[p] = 0;
            e_rdy[p]  = 0;
        end
    endtask

    // Applies the current inputs for one clock and checks every read port.
    task automatic do_cycle();
        bit h1, h2;
        for (int p = 0; p < 4; p++) begin
            if (re[p]) begin
                h1 = we1 && wa1 != 0 && wa1 == ra[p];
                h2 = we2 && wa2 != 0 && wa2 == ra[p];
                if (ra[p] == 0) begin
                    e_data[p] = 0;           e_rdy[p] = 1;
                end else if (h2) begin
                    e_data[p] = wd2;         e_rdy[p] = 1;
                end else if (h1) begin
                    e_data[p] = wd1;         e_rdy[p] = 1;
                end else begin
                    e_data[p] = m_mem[ra[p]]; e_rdy[p] = !m_busy[ra[p]];
                end
            end
        end
        @(posedge clk);
        if (we1 && wa1 != 0) begin m_mem[wa1] = wd1; m_busy[wa1] = 0; end
        if (we2 && wa2 != 0) begin m_mem[wa2] = wd2; m_busy[wa2] = 0; end
        if (ae1 && aa1 != 0) m_busy[aa1] = 1;
        if (ae2 && aa2 != 0) m_busy[aa2] = 1;
        #1;
        for (int p = 0; p < 4; p++) begin
            chk($sformatf("port%0d_data", p), rd[p], e_data[p]);
            chk($sformatf("port%0d_rdy", p), {31'b0, rr[p]}, {31'b0, e_rdy[p]});
        end
        @(negedge clk);
    endtask

    initial begin
        clear_inputs();
        model_reset();
        #1 rst_n = 0;
        #2;
        for (int p = 0; p < 4; p++) begin
            chk("reset_data", rd[p], 32'h0);
            chk("reset_rdy", {31'b0, rr[p]}, 32'h0);
        end
        @(negedge clk);
        rst_n = 1;

        // Reads straight after reset.
        re[0] = 1; ra[0] = 5;  re[1] = 1; ra[1] = 0;
        re[2] = 1; ra[2] = 31; re[3] = 1; ra[3] = 1;
        do_cycle();
        for (int p = 0; p < 4; p++) chk("post_reset_rdy", {31'b0, rr[p]}, 32'h1);
        clear_inputs();

        // Write then read.
        we1 = 1; wa1 = 3; wd1 = 32'hDEADBEEF;
        do_cycle();
        clear_inputs();
        re[0] = 1; ra[0] = 3;
        do_cycle();
        chk("wr_rd_data", rd[0], 32'hDEADBEEF);
        chk("wr_rd_rdy", {31'b0, rr[0]}, 32'h1);
        clear_inputs();

        // Same-cycle collision with bypass read.
        we1 = 1; wa1 = 7; wd1 = 32'h11;
        we2 = 1; wa2 = 7; wd2 = 32'h22;
        re[3] = 1; ra[3] = 7;
        do_cycle();
        chk("bypass_coll", rd[3], 32'h22);
        clear_inputs();
        re[2] = 1; ra[2] = 7;
        do_cycle();
        chk("coll_stored", rd[2], 32'h22);
        chk("hold_port3", rd[3], 32'h22);
        clear_inputs();

        // x0 immunity.
        we1 = 1; wa1 = 0; wd1 = 32'hFFFFFFFF; ae1 = 1; aa1 = 0;
        do_cycle();
        clear_inputs();
        re[1] = 1; ra[1] = 0;
        do_cycle();
        chk("x0_data", rd[1], 32'h0);
        chk("x0_rdy", {31'b0, rr[1]}, 32'h1);
        clear_inputs();

        // Scoreboard sequence on x9.
        ae1 = 1; aa1 = 9;
        do_cycle();
        clear_inputs();
        re[0] = 1; ra[0] = 9;
        do_cycle();
        chk("sb_busy_rdy", {31'b0, rr[0]}, 32'h0);
        clear_inputs();
        we2 = 1; wa2 = 9; wd2 = 32'h55; re[1] = 1; ra[1] = 9;
        do_cycle();
        chk("sb_wr_data", rd[1], 32'h55);
        chk("sb_wr_rdy", {31'b0, rr[1]}, 32'h1);
        clear_inputs();
        ae2 = 1; aa2 = 9; we1 = 1; wa1 = 9; wd1 = 32'h66;
        do_cycle();
        clear_inputs();
        re[2] = 1; ra[2] = 9;
        do_cycle();
        chk("sb_realloc_data", rd[2], 32'h66);
        chk("sb_realloc_rdy", {31'b0, rr[2]}, 32'h0);
        clear_inputs();

        // Asynchronous reset mid-stream.
        for (int i = 1; i <= 4; i++) begin
            we1 = 1; wa1 = 5'(i); wd1 = 32'hA0 + 32'(i);
            do_cycle();
        end
        clear_inputs();
        ae1 = 1; aa1 = 5;
        for (int p = 0; p < 4; p++) begin re[p] = 1; ra[p] = 5'(p + 1); end
        do_cycle();
        clear_inputs();
        #1 rst_n = 0;
        model_reset();
        #1;
        for (int p = 0; p < 4; p++) begin
            chk("async_rst_data", rd[p], 32'h0);
            chk("async_rst_rdy", {31'b0, rr[p]}, 32'h0);
        end
        #1 rst_n = 1;
        @(negedge clk);
        re[0] = 1; ra[0] = 1; re[1] = 1; ra[1] = 5;
        do_cycle();
        chk("rst_x1_data", rd[0], 32'h0);
        chk("rst_x5_rdy", {31'b0, rr[1]}, 32'h1);
        clear_inputs();

        // Randomized traffic, mostly on a narrow index range to force hits.
        for (int c = 0; c < 400; c++) begin
            bit narrow;
            narrow = ($urandom_range(0, 3) != 0);
            we1 = 1'($urandom); wa1 = narrow ? 5'($urandom_range(0, 7)) : 5'($urandom);
            we2 = 1'($urandom); wa2 = narrow ? 5'($urandom_range(0, 7)) : 5'($urandom);
            wd1 = $urandom; wd2 = $urandom;
            ae1 = ($urandom_range(0, 3) == 0); aa1 = narrow ? 5'($urandom_range(0, 7)) : 5'($urandom);
            ae2 = ($urandom_range(0, 3) == 0); aa2 = narrow ? 5'($urandom_range(0, 7)) : 5'($urandom);
            for (int p = 0; p < 4; p++) begin
                re[p] = ($urandom_range(0, 3) != 0);
                ra[p] = narrow ? 5'($urandom_range(0, 7)) : 5'($urandom);
            end
            do_cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
